// File: rtl/mapping_group_pkg.sv
// Shared types, default widths and the saturation helper for the mapping group
// accumulator and its per-channel slices.
package mapping_group_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } mg_state_e;

    localparam int NUM_CH_DEF     = 4;
    localparam int IN_W_DEF       = 7;
    localparam int MAX_PLANES_DEF = 8;
    localparam int ACC_W_DEF      = 24;
    localparam int OUT_W_DEF      = 32;
    localparam int ZP_W           = 32;
    localparam int SUM_W          = 33;

    // Returns {clamped_flag, value clamped to the signed out_w range, still SUM_W wide}.
    function automatic logic [SUM_W:0] sat_to_w(input logic signed [SUM_W-1:0] val,
                                                 input int out_w);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = $signed((SUM_W'(1) << (out_w - 1)) - SUM_W'(1));
        lo = ~hi;
        if (val > hi) begin
            return {1'b1, hi};
        end
        if (val < lo) begin
            return {1'b1, lo};
        end
        return {1'b0, val};
    endfunction

endpackage

// File: rtl/mg_channel_acc.sv
// One channel of the mapping group: shift-accumulates weighted bit planes, then adds
// the zero point and saturates or wraps into the registered result.
module mg_channel_acc
    import mapping_group_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    abort_i,
    input  logic                    drain_i,
    input  logic                    first_i,
    input  logic                    acc_en_i,
    input  logic                    last_i,
    input  logic                    neg_i,
    input  logic                    sat_en_i,
    input  logic [CNT_W-1:0]        shift_i,
    input  logic [IN_W-1:0]         data_i,
    input  logic signed [ZP_W-1:0]  zp_i,
    output logic [OUT_W-1:0]        out_data_o,
    output logic                    sat_flag_o
);

    logic [ACC_W-1:0]        mag;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] sum;
    logic [SUM_W:0]          sat_res;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    sat_flag_q, sat_flag_d;
    logic                    unused_sat_hi;

    always_comb begin
        mag      = {{(ACC_W-IN_W){1'b0}}, data_i} << shift_i;
        term     = neg_i ? -$signed(mag) : $signed(mag);
        // The first plane starts from zero so a stale accumulator can never leak in.
        acc_next = (first_i ? '0 : acc_q) + term;
        sum      = $signed({{(SUM_W-ACC_W){acc_next[ACC_W-1]}}, acc_next})
                 + $signed({zp_i[ZP_W-1], zp_i});
        sat_res  = sat_to_w(sum, OUT_W);

        acc_d      = acc_q;
        out_data_d = out_data_q;
        sat_flag_d = sat_flag_q;
        if (abort_i) begin
            acc_d      = '0;
            sat_flag_d = 1'b0;
        end else if (drain_i) begin
            acc_d = '0;
        end else begin
            if (first_i || acc_en_i) begin
                acc_d = acc_next;
            end
            if (last_i) begin
                if (sat_en_i) begin
                    out_data_d = sat_res[OUT_W-1:0];
                    sat_flag_d = sat_res[SUM_W];
                end else begin
                    out_data_d = sum[OUT_W-1:0];
                    sat_flag_d = 1'b0;
                end
            end
        end
    end

    assign unused_sat_hi = ^sat_res[SUM_W-1:OUT_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            out_data_q <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign out_data_o = out_data_q;
    assign sat_flag_o = sat_flag_q;

endmodule

// File: rtl/mapping_group_acc_v2.sv
// Parametrised mapping group: collects LSB-first bit planes from NUM_CH PIM channels,
// produces zero-point adjusted results on a valid/ready port with input backpressure.
module mapping_group_acc_v2
    import mapping_group_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int MAX_PLANES = MAX_PLANES_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    localparam int P_W       = $clog2(MAX_PLANES + 1),
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [P_W-1:0]          cfg_planes_i,
    input  logic                    cfg_signed_i,
    input  logic                    cfg_sat_en_i,
    input  logic                    zp_we_i,
    input  logic [SEL_W-1:0]        zp_sel_i,
    input  logic [ZP_W-1:0]         zp_data_i,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [NUM_CH*IN_W-1:0]  in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [NUM_CH*OUT_W-1:0] out_data_o,
    output logic [NUM_CH-1:0]       sat_flag_o,
    output logic                    busy_o
);

    if (ACC_W < IN_W + MAX_PLANES + 1) begin : g_acc_w_chk
        $error("ACC_W too narrow for IN_W + MAX_PLANES + 1");
    end
    if (ACC_W >= SUM_W || OUT_W >= SUM_W || NUM_CH < 2) begin : g_shape_chk
        $error("ACC_W and OUT_W must be below 33 bits and NUM_CH at least 2");
    end

    mg_state_e          state_q, state_d;
    logic [P_W-1:0]     cnt_q, cnt_d;
    logic [P_W-1:0]     planes_q, planes_d;
    logic               signed_q, signed_d;
    logic               sat_en_q, sat_en_d;
    logic [P_W-1:0]     eff_planes, cur_planes, last_idx;
    logic               is_idle, cur_signed, cur_sat_en;
    logic               in_fire, first_fire, acc_fire, last_fire, out_fire, neg_plane;
    logic signed [ZP_W-1:0] zp_q [NUM_CH];
    logic signed [ZP_W-1:0] zp_d [NUM_CH];

    // In IDLE the config inputs act directly so a single-plane result uses them at once.
    always_comb begin
        eff_planes = cfg_planes_i;
        if (cfg_planes_i == '0) begin
            eff_planes = P_W'(1);
        end else if (cfg_planes_i > P_W'(MAX_PLANES)) begin
            eff_planes = P_W'(MAX_PLANES);
        end
        is_idle    = (state_q == IDLE);
        cur_planes = is_idle ? eff_planes   : planes_q;
        cur_signed = is_idle ? cfg_signed_i : signed_q;
        cur_sat_en = is_idle ? cfg_sat_en_i : sat_en_q;
        last_idx   = cur_planes - P_W'(1);

        in_ready_o  = (state_q != OUT);
        out_valid_o = (state_q == OUT);
        busy_o      = !is_idle;
        in_fire     = in_valid_i && in_ready_o && !clear_i;
        first_fire  = in_fire && is_idle;
        acc_fire    = in_fire && (state_q == ACCUM);
        last_fire   = in_fire && (cnt_q == last_idx);
        out_fire    = out_valid_o && out_ready_i && !clear_i;
        neg_plane   = cur_signed && (cnt_q == last_idx);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        planes_d = planes_q;
        signed_d = signed_q;
        sat_en_d = sat_en_q;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        planes_d = eff_planes;
                        signed_d = cfg_signed_i;
                        sat_en_d = cfg_sat_en_i;
                        cnt_d    = P_W'(1);
                        state_d  = last_fire ? OUT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        cnt_d = cnt_q + P_W'(1);
                        if (last_fire) begin
                            state_d = OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Out-of-range selects simply match no entry.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            zp_d[c] = zp_q[c];
            if (zp_we_i && (zp_sel_i == SEL_W'(c))) begin
                zp_d[c] = zp_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            planes_q <= '0;
            signed_q <= 1'b0;
            sat_en_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                zp_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            planes_q <= planes_d;
            signed_q <= signed_d;
            sat_en_q <= sat_en_d;
            for (int c = 0; c < NUM_CH; c++) begin
                zp_q[c] <= zp_d[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mg_channel_acc #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W),
            .OUT_W (OUT_W),
            .CNT_W (P_W)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .abort_i    (clear_i),
            .drain_i    (out_fire),
            .first_i    (first_fire),
            .acc_en_i   (acc_fire),
            .last_i     (last_fire),
            .neg_i      (neg_plane),
            .sat_en_i   (cur_sat_en),
            .shift_i    (cnt_q),
            .data_i     (in_data_i[(NUM_CH-1-c)*IN_W +: IN_W]),
            .zp_i       (zp_q[c]),
            .out_data_o (out_data_o[(NUM_CH-1-c)*OUT_W +: OUT_W]),
            .sat_flag_o (sat_flag_o[c])
        );
    end

endmodule

// File: tb/tb_mapping_group_acc_v2.sv
// Scoreboard bench for mapping_group_acc_v2: expected results are queued as planes are
// driven and compared whenever the output port handshakes.
module tb_mapping_group_acc_v2;

    localparam int NCH = 4;
    localparam int IW  = 7;
    localparam int MP  = 8;
    localparam int OW  = 32;
    localparam int PW  = 4;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PW-1:0]     cfg_planes = '0;
    logic              cfg_signed = 1'b0;
    logic              cfg_sat = 1'b0;
    logic              zp_we = 1'b0;
    logic [SW-1:0]     zp_sel = '0;
    logic [31:0]       zp_data = '0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NCH*IW-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NCH*OW-1:0] out_data;
    logic [NCH-1:0]    sat_flag;
    logic              busy;

    mapping_group_acc_v2 dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_planes_i (cfg_planes),
        .cfg_signed_i (cfg_signed),
        .cfg_sat_en_i (cfg_sat),
        .zp_we_i      (zp_we),
        .zp_sel_i     (zp_sel),
        .zp_data_i    (zp_data),
        .clear_i      (clear),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .sat_flag_o   (sat_flag),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*OW-1:0] data;
        logic [NCH-1:0]    flags;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    int     pd[MP][NCH];
    longint zp_m[NCH];

    // Scoreboard consumer: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_output got %h expected none", out_data);
            end else begin
                mon_e = sbq.pop_front();
                if (out_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_data got %h expected %h", out_data, mon_e.data);
                end
                checks++;
                if (sat_flag !== mon_e.flags) begin
                    errors++;
                    $display("FAIL sb_sat_flag got %b expected %b", sat_flag, mon_e.flags);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_p(int cfg);
        if (cfg == 0) return 1;
        if (cfg > MP) return MP;
        return cfg;
    endfunction

    function automatic logic [31:0] ch_out(int c);
        return out_data[(NCH-1-c)*OW +: OW];
    endfunction

    task automatic zp_write(int sel, int val);
        zp_we   = 1'b1;
        zp_sel  = sel[SW-1:0];
        zp_data = val;
        tick();
        zp_we = 1'b0;
        zp_m[sel] = longint'(val);
    endtask

    task automatic rand_planes();
        for (int k = 0; k < MP; k++)
            for (int c = 0; c < NCH; c++)
                pd[k][c] = int'($urandom_range(0, 127));
    endtask

    task automatic push_expected(int cfg, bit sgn, bit sat);
        exp_t   e;
        int     p;
        longint acc, s, term;
        p = eff_p(cfg);
        e.data  = '0;
        e.flags = '0;
        for (int c = 0; c < NCH; c++) begin
            acc = 0;
            for (int k = 0; k < p; k++) begin
                term = longint'(pd[k][c]) * (longint'(1) << k);
                if (sgn && k == p - 1) acc = acc - term;
                else                   acc = acc + term;
            end
            s = acc + zp_m[c];
            if (sat && s > 64'sd2147483647) begin
                e.data[(NCH-1-c)*OW +: OW] = 32'h7FFF_FFFF;
                e.flags[c] = 1'b1;
            end else if (sat && s < -64'sd2147483648) begin
                e.data[(NCH-1-c)*OW +: OW] = 32'h8000_0000;
                e.flags[c] = 1'b1;
            end else begin
                e.data[(NCH-1-c)*OW +: OW] = s[31:0];
            end
        end
        sbq.push_back(e);
    endtask

    // Drives one plane and returns #1 after the edge on which it was accepted.
    task automatic send_plane(int k, int cfg, bit sgn, bit sat);
        int n;
        for (int c = 0; c < NCH; c++) in_data[(NCH-1-c)*IW +: IW] = pd[k][c][IW-1:0];
        cfg_planes = cfg[PW-1:0];
        cfg_signed = sgn;
        cfg_sat    = sat;
        in_valid   = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_timeout got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Later planes carry scrambled config, which the DUT must ignore.
    task automatic send_result(int cfg, bit sgn, bit sat, int gaps);
        int p;
        p = eff_p(cfg);
        push_expected(cfg, sgn, sat);
        for (int k = 0; k < p; k++) begin
            if (k == 0) send_plane(k, cfg, sgn, sat);
            else        send_plane(k, int'($urandom_range(0, 15)), ~sgn, ~sat);
            if (k < p - 1) repeat (gaps) tick();
        end
    endtask

    task automatic consume();
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout got %b expected 1", out_valid);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
        checks++; if (sat_flag !== '0) begin errors++; $display("FAIL reset_sat_flag got %b expected 0", sat_flag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    endtask

    task automatic test_unsigned_p1();
        pd[0][0] = 127; pd[0][1] = 5; pd[0][2] = 0; pd[0][3] = 77;
        send_result(1, 1'b0, 1'b0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL p1_latency got %b expected 1", out_valid); end
        checks++; if (ch_out(0) !== 32'd127) begin errors++; $display("FAIL p1_ch0 got %h expected 0000007f", ch_out(0)); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL p1_in_ready_out got %b expected 0", in_ready); end
        consume();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p1_busy_after got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL p1_in_ready_after got %b expected 1", in_ready); end
    endtask

    task automatic test_signed_p4();
        zp_write(0, 5);
        zp_write(2, -3);
        rand_planes();
        pd[0][0] = 3; pd[1][0] = 1; pd[2][0] = 0; pd[3][0] = 2;
        send_result(4, 1'b1, 1'b0, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL p4_latency got %b expected 1", out_valid); end
        checks++; if (ch_out(0) !== 32'hFFFF_FFFA) begin errors++; $display("FAIL p4_ch0 got %h expected fffffffa", ch_out(0)); end
        checks++; if (sat_flag[0] !== 1'b0) begin errors++; $display("FAIL p4_flag0 got %b expected 0", sat_flag[0]); end
        consume();
    endtask

    task automatic test_saturation();
        zp_write(1, 32'h7FFF_FFFF);
        rand_planes();
        pd[0][1] = 100;
        send_result(1, 1'b0, 1'b1, 0);
        checks++; if (ch_out(1) !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_on_ch1 got %h expected 7fffffff", ch_out(1)); end
        checks++; if (sat_flag[1] !== 1'b1) begin errors++; $display("FAIL sat_on_flag1 got %b expected 1", sat_flag[1]); end
        consume();
        send_result(1, 1'b0, 1'b0, 0);
        checks++; if (ch_out(1) !== 32'h8000_0063) begin errors++; $display("FAIL sat_off_ch1 got %h expected 80000063", ch_out(1)); end
        checks++; if (sat_flag[1] !== 1'b0) begin errors++; $display("FAIL sat_off_flag1 got %b expected 0", sat_flag[1]); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [NCH*OW-1:0] held;
        rand_planes();
        send_result(2, 1'b0, 1'b0, 0);
        held = out_data;
        zp_write(0, 1000);
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b expected 0", i, in_ready); end
            checks++; if (out_data !== held) begin errors++; $display("FAIL bp_hold cycle %0d got %h expected %h", i, out_data, held); end
            tick();
        end
        consume();
        rand_planes();
        pd[0][0] = 10;
        send_result(1, 1'b0, 1'b0, 0);
        checks++; if (ch_out(0) !== 32'd1010) begin errors++; $display("FAIL bp_new_zp got %h expected 000003f2", ch_out(0)); end
        consume();
    endtask

    task automatic test_zp_same_cycle();
        longint old_zp;
        rand_planes();
        old_zp = zp_m[3];
        push_expected(1, 1'b0, 1'b0);
        zp_we = 1'b1; zp_sel = 2'd3; zp_data = 32'd12345;
        send_plane(0, 1, 1'b0, 1'b0);
        zp_we = 1'b0;
        zp_m[3] = 12345;
        checks++;
        if (ch_out(3) !== 32'(longint'(pd[0][3]) + old_zp)) begin
            errors++; $display("FAIL zp_same_cycle got %h expected old zp used", ch_out(3));
        end
        consume();
        rand_planes();
        send_result(1, 1'b0, 1'b0, 0);
        checks++; if (ch_out(3) !== 32'(pd[0][3] + 12345)) begin errors++; $display("FAIL zp_next_result got %h expected %h", ch_out(3), 32'(pd[0][3] + 12345)); end
        consume();
    endtask

    task automatic test_abort_gaps();
        rand_planes();
        for (int k = 0; k < 3; k++) begin
            send_plane(k, 8, 1'b0, 1'b0);
            repeat (2) tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid plane %0d got %b expected 0", k, out_valid); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy plane %0d got %b expected 1", k, busy); end
        end
        clear = 1'b1;
        in_valid = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b expected 0", out_valid); end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) pd[k][c] = 1;
        send_result(2, 1'b0, 1'b0, 0);
        checks++; if (ch_out(0) !== 32'd1003) begin errors++; $display("FAIL abort_fresh_ch0 got %h expected 000003eb", ch_out(0)); end
        checks++; if (ch_out(2) !== 32'h0000_0000) begin errors++; $display("FAIL abort_fresh_ch2 got %h expected 00000000", ch_out(2)); end
        consume();
    endtask

    task automatic test_clamp();
        rand_planes();
        send_result(0, 1'b1, 1'b0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clamp_p0 got out_valid %b expected 1", out_valid); end
        consume();
        rand_planes();
        send_result(15, 1'b0, 1'b1, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clamp_p15 got out_valid %b expected 1", out_valid); end
        consume();
    endtask

    task automatic test_back_to_back();
        int cfg;
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0) zp_write(i % NCH, int'($urandom));
            rand_planes();
            cfg = int'($urandom_range(0, 15));
            send_result(cfg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i % 2);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_latency iter %0d got %b expected 1", i, out_valid); end
            consume();
        end
    endtask

    task automatic test_reset_mid_out();
        rand_planes();
        send_result(1, 1'b0, 1'b0, 0);
        sbq.delete();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_mid_data got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) zp_m[c] = 0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b expected 1", in_ready); end
        rand_planes();
        send_result(1, 1'b0, 1'b1, 0);
        checks++; if (ch_out(1) !== 32'(pd[0][1])) begin errors++; $display("FAIL rst_zp_cleared got %h expected %h", ch_out(1), 32'(pd[0][1])); end
        consume();
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) zp_m[c] = 0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_unsigned_p1();
        test_signed_p4();
        test_saturation();
        test_backpressure();
        test_zp_same_cycle();
        test_abort_gaps();
        test_clamp();
        test_back_to_back();
        test_reset_mid_out();
        repeat (2) tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mapping_group_acc_v2.md
Name: mapping_group_acc_v2

Overview:
- Parametrised successor to the fixed 4-channel mapping group.
- Accepts per-cycle bit-plane partial sums from NUM_CH PIM channels and shift-accumulates them over a configurable number of planes (LSB first).
- Supports two's-complement weighting of the MSB plane.
- Adds a per-channel zero point, with optional saturation, and presents the result on a valid/ready output port with backpressure to the input.

Parameters:
- NUM_CH, 4, number of channels.
- IN_W, 7, unsigned partial-sum width per channel per plane.
- MAX_PLANES, 8, maximum bit planes per result.
- ACC_W, 24, signed accumulator width; must be >= IN_W+MAX_PLANES+1 (elaboration assertion).
- OUT_W, 32, signed output width per channel.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- cfg_planes_i  in  $clog2(MAX_PLANES+1)  planes per result; sampled on first-plane handshake.
- cfg_signed_i  in  1  MSB plane carries negative weight; sampled with cfg_planes_i.
- cfg_sat_en_i  in  1  saturate (1) or wrap (0); sampled with cfg_planes_i.
- zp_we_i  in  1  zero-point write strobe.
- zp_sel_i  in  $clog2(NUM_CH)  zero-point channel index.
- zp_data_i  in  32  signed zero point.
- clear_i  in  1  synchronous abort.
- in_valid_i  in  1  plane data valid.
- in_ready_o  out  1  plane data accepted.
- in_data_i  in  NUM_CH*IN_W  partial sums; channel 0 in MSBs.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed.
- out_data_o  out  NUM_CH*OUT_W  results; channel 0 in MSBs.
- sat_flag_o  out  NUM_CH  per-channel saturation occurred for this result.
- busy_o  out  1  state != IDLE.

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_ni low clears all state immediately.
- Reset values:
  - state IDLE; accumulators 0; plane counter 0.
  - zero-point registers 0; latched config 0.
  - out_valid_o 0, out_data_o 0, sat_flag_o 0, busy_o 0.
  - in_ready_o 1 (combinational from IDLE).
- FSM states IDLE, ACCUM, OUT.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i, latch cfg. Effective planes P = cfg_planes_i clamped to 1..MAX_PLANES (0 -> 1, >MAX -> MAX).
  - acc[c] = weight(0)*data[c]; cnt=1.
  - Go to OUT if P==1, else ACCUM.
- ACCUM:
  - in_ready_o=1.
  - Each handshake: acc[c] += weight(cnt)*(data[c] << cnt); cnt++.
  - When the accepted plane is P-1, go to OUT.
  - No handshake -> hold (gaps allowed).
- weight(k) = -1 if signed and k==P-1, else +1. P==1 and signed means a single negative plane.
- Result computation:
  - On the cycle the last plane is accepted, compute sum[c] = sext(acc_next[c]) + zp[c] at 33 bits.
  - If sat_en: clamp to the signed OUT_W range and set sat_flag_o[c] when clamped. Else take the low OUT_W bits with sat_flag_o[c]=0.
  - Register sum into out_data_o. Latency: out_valid_o rises the cycle after the last-plane handshake.
- OUT:
  - in_ready_o=0; out_valid_o=1.
  - out_data_o and sat_flag_o are held stable until out_ready_i.
  - On handshake: out_valid_o=0, accumulators and cnt cleared, go to IDLE. A new first plane can be accepted the following cycle (no same-cycle bypass).
- Zero-point writes:
  - zp_we_i writes zp[zp_sel_i] in any state, effective the next cycle.
  - A write in the same cycle as the last-plane handshake is NOT used for that result; the old value is used.
  - Writes during OUT do not alter held data.
  - zp_sel_i >= NUM_CH is ignored.
- clear_i has highest priority over everything except reset:
  - Go to IDLE; accumulators, cnt, out_valid_o and sat_flag_o are cleared. Zero points are kept.
  - Any same-cycle in_valid_i is dropped.
  - Dropping out_valid_o without a handshake is legal only via clear_i.
- Config inputs are ignored after the first plane until the return to IDLE.

Decomposition:
- mapping_group_pkg holds:
  - the state enum mg_state_e (IDLE, ACCUM, OUT);
  - the default width constants;
  - the function sat_to_w (33-bit signed to OUT_W with a flag).
- Sub-module mg_channel_acc handles one channel: accumulator, plane weighting/shift, zp add, saturation. It is generated NUM_CH times.
- FSM, counter, handshake and zp register file stay in the top.

Test Plan:
- Unsigned, P=1, zp[0]=0: ch0 data 127 -> next cycle out_valid_o=1, ch0 out 127; out_ready_i=1 -> IDLE, busy_o=0.
- Signed, P=4, zp[0]=5: ch0 planes 3,1,0,2 (LSB first) -> 3+2+0-16=-11, +5 -> 0xFFFFFFFA; sat_flag_o[0]=0.
- Saturation: zp[1]=0x7FFFFFFF, P=1, ch1 data 100:
  - sat_en=1 -> 0x7FFFFFFF, sat_flag_o[1]=1.
  - sat_en=0 -> 0x80000063, sat_flag_o[1]=0.
- Backpressure: hold out_ready_i=0 for 5 cycles in OUT -> in_ready_o=0, out_data_o stable.
  - Same test: zp write during OUT does not change out_data_o; the next result uses the new zp.
- Abort and gaps: P=8, 3 planes accepted with idle gaps, then clear_i -> IDLE next cycle, out_valid_o never asserted. Next P=2 result: planes 1,1 -> 3 (stale accumulation absent).
- Reset mid-OUT: drop rst_ni while out_valid_o=1 -> outputs 0 immediately, zp registers 0, in_ready_o=1 after release.
- Clamp: cfg_planes_i=0 -> P=1 (result after 1 plane).
